// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong buffer turning bit-reversed FFT pairs into a natural-order stream; FFT_OUT_INDEX_EN adds o_index
`timescale 1ns/1ps
module fft_out_reorder #(
    parameter int LOG2N = 10,
    parameter int DW    = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_valid_in,
    input  logic [DW-1:0] i_data_a_real,
    input  logic [DW-1:0] i_data_a_imag,
    input  logic [DW-1:0] i_data_b_real,
    input  logic [DW-1:0] i_data_b_imag,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_real,
    output logic [DW-1:0] o_imag,
    output logic          o_last,
`ifdef FFT_OUT_INDEX_EN
    output logic [LOG2N-1:0] o_index,
`endif
    output logic          o_overflow
);
    localparam int N  = 1 << LOG2N;
    localparam int AW = LOG2N - 1;
    typedef enum logic [1:0] {FREE, FILLING, FULL, READING} bank_t;
    typedef enum logic [1:0] {IDLE, PRIME, STREAM} rd_t;
    logic [2*DW-1:0] mem_lo [N];
    logic [2*DW-1:0] mem_hi [N];
    bank_t bst_q [2];
    bank_t bst_d [2];
    rd_t st_q, st_d;
    logic [AW-1:0] k_q, k_d, waddr;
    logic [LOG2N-1:0] n_q, n_d, raddr;
    logic [DW-1:0] re_q, re_d, im_q, im_d;
    logic wb_q, wb_d, rb_q, rb_d, drop_q, drop_d, ovf_q, ovf_d, oldest_q, oldest_d, last_q, last_d;
    logic start, wrap, drop_now, wen, pick, ren;

    // Write address is the bit-reversed pair count; a frame landing on a busy bank is dropped whole
    always_comb begin
        waddr = '0;
        for (int i = 0; i < AW; i++) waddr[i] = k_q[AW-1-i];
        start    = k_q == '0;
        wrap     = k_q == AW'(N/2 - 1);
        drop_now = start ? (bst_q[wb_q] != FREE) : drop_q;
        wen      = i_valid_in && !drop_now;
    end

    // Next state for bank bookkeeping, write counters and the read FSM
    always_comb begin
        k_d      = k_q;
        wb_d     = wb_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        oldest_d = oldest_q;
        bst_d    = bst_q;
        st_d     = st_q;
        rb_d     = rb_q;
        n_d      = n_q;
        re_d     = re_q;
        im_d     = im_q;
        last_d   = last_q;
        ren      = 1'b0;
        raddr    = n_q;
        pick     = (bst_q[0] == FULL && bst_q[1] == FULL) ? oldest_q : (bst_q[1] == FULL);
        if (i_valid_in) begin
            k_d    = k_q + 1'b1;
            drop_d = drop_now;
            ovf_d  = ovf_q | (start & drop_now);
            if (wen) bst_d[wb_q] = wrap ? FULL : FILLING;
            if (wen && wrap && bst_q[!wb_q] != FULL) oldest_d = wb_q;
            if (wrap) wb_d = !wb_q;
        end
        case (st_q)
            IDLE: if (bst_q[0] == FULL || bst_q[1] == FULL) begin
                st_d        = PRIME;
                rb_d        = pick;
                bst_d[pick] = READING;
            end
            PRIME: begin
                ren    = 1'b1;
                raddr  = '0;
                n_d    = '0;
                last_d = 1'b0;
                st_d   = STREAM;
            end
            default: if (i_ready) begin
                if (n_q == LOG2N'(N - 1)) begin
                    bst_d[rb_q] = FREE;
                    last_d      = 1'b0;
                    st_d        = (bst_q[!rb_q] == FULL) ? PRIME : IDLE;
                    if (bst_q[!rb_q] == FULL) begin
                        rb_d         = !rb_q;
                        bst_d[!rb_q] = READING;
                    end
                end else begin
                    ren    = 1'b1;
                    raddr  = n_q + 1'b1;
                    n_d    = n_q + 1'b1;
                    last_d = (n_q + 1'b1) == LOG2N'(N - 1);
                end
            end
        endcase
        if (ren) {re_d, im_d} = raddr[LOG2N-1] ? mem_hi[{rb_q, raddr[AW-1:0]}] : mem_lo[{rb_q, raddr[AW-1:0]}];
    end

    // A goes to LO, B to HI, same address and cycle
    always_ff @(posedge i_clk) begin
        if (wen) begin
            mem_lo[{wb_q, waddr}] <= {i_data_a_real, i_data_a_imag};
            mem_hi[{wb_q, waddr}] <= {i_data_b_real, i_data_b_imag};
        end
    end

    // State registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            bst_q[0] <= FREE;
            bst_q[1] <= FREE;
            st_q     <= IDLE;
            k_q      <= '0;
            wb_q     <= 1'b0;
            rb_q     <= 1'b0;
            drop_q   <= 1'b0;
            ovf_q    <= 1'b0;
            oldest_q <= 1'b0;
            n_q      <= '0;
            re_q     <= '0;
            im_q     <= '0;
            last_q   <= 1'b0;
        end else begin
            bst_q    <= bst_d;
            st_q     <= st_d;
            k_q      <= k_d;
            wb_q     <= wb_d;
            rb_q     <= rb_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            oldest_q <= oldest_d;
            n_q      <= n_d;
            re_q     <= re_d;
            im_q     <= im_d;
            last_q   <= last_d;
        end
    end

    assign o_valid    = st_q == STREAM;
    assign o_real     = re_q;
    assign o_imag     = im_q;
    assign o_last     = last_q;
    assign o_overflow = ovf_q;
`ifdef FFT_OUT_INDEX_EN
    assign o_index    = n_q;
`endif
endmodule
